// File: rtl/mem_responder.sv
// mem_responder: responder end of the wr/rd request/return memory interface.
// Always accepts one write and one read request per clock (no backpressure),
// stores write data in a word array and returns ack/address(/data) after
// fixed latencies through plain valid-bit shift pipelines.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   wr_en, wr_address, wr_data      write request
//   wr_ret_ack, wr_ret_address      write return (one-cycle pulse)
//   rd_en, rd_address               read request
//   rd_ret_ack, rd_ret_address,
//   rd_ret_data                     read return (one-cycle pulse)
//   wr_count, rd_count              saturating accepted-request counters
module mem_responder #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned IDX_W      = 10,
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned WR_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_ret_address,
    output logic              wr_ret_ack,
    input  logic [ADDR_W-1:0] rd_address,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_ret_data,
    output logic [ADDR_W-1:0] rd_ret_address,
    output logic              rd_ret_ack,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);

    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Upper address bits are ignored for storage (aliasing).
    assign wr_idx = wr_address[IDX_W-1:0];
    assign rd_idx = rd_address[IDX_W-1:0];

    // Pipeline stages; stage 0 is loaded at the request sample edge.
    logic              wr_v [WR_LATENCY];
    logic [ADDR_W-1:0] wr_a [WR_LATENCY];
    logic              rd_v [RD_LATENCY];
    logic [ADDR_W-1:0] rd_a [RD_LATENCY];
    logic [DATA_W-1:0] rd_d [RD_LATENCY];

    // Word storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Write return pipeline; address/data fields are zero when not valid,
    // so the last stage drives idle outputs to 0 directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WR_LATENCY; i++) begin
                wr_v[i] <= 1'b0;
                wr_a[i] <= '0;
            end
        end else begin
            wr_v[0] <= wr_en;
            wr_a[0] <= wr_en ? wr_address : '0;
            for (int i = 1; i < WR_LATENCY; i++) begin
                wr_v[i] <= wr_v[i-1];
                wr_a[i] <= wr_a[i-1];
            end
        end
    end

    // Read return pipeline; the array is sampled with the pre-write value
    // because the storage update is also a non-blocking assignment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_v[i] <= 1'b0;
                rd_a[i] <= '0;
                rd_d[i] <= '0;
            end
        end else begin
            rd_v[0] <= rd_en;
            rd_a[0] <= rd_en ? rd_address : '0;
            rd_d[0] <= rd_en ? mem[rd_idx] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_v[i] <= rd_v[i-1];
                rd_a[i] <= rd_a[i-1];
                rd_d[i] <= rd_d[i-1];
            end
        end
    end

    assign wr_ret_ack     = wr_v[WR_LATENCY-1];
    assign wr_ret_address = wr_a[WR_LATENCY-1];
    assign rd_ret_ack     = rd_v[RD_LATENCY-1];
    assign rd_ret_address = rd_a[RD_LATENCY-1];
    assign rd_ret_data    = rd_d[RD_LATENCY-1];

    // Saturating request counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (wr_en && (wr_count != CNT_MAX)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
            if (rd_en && (rd_count != CNT_MAX)) begin
                rd_count <= rd_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a transaction-level model (word map
// plus queues of pending responses with due edges) is compared against the
// DUT every cycle, and hand-computed literal expectations pin key cases.
module tb_mem_responder;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 10;
    localparam int unsigned RD_L   = 4;
    localparam int unsigned WR_L   = 2;

    localparam int S_WR_ACK  = 0;
    localparam int S_WR_ADDR = 1;
    localparam int S_RD_ACK  = 2;
    localparam int S_RD_ADDR = 3;
    localparam int S_RD_DATA = 4;
    localparam int S_WR_CNT  = 5;
    localparam int S_RD_CNT  = 6;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] wr_address = '0;
    logic              wr_en      = 1'b0;
    logic [DATA_W-1:0] wr_data    = '0;
    logic [ADDR_W-1:0] rd_address = '0;
    logic              rd_en      = 1'b0;
    logic [ADDR_W-1:0] wr_ret_address;
    logic              wr_ret_ack;
    logic [DATA_W-1:0] rd_ret_data;
    logic [ADDR_W-1:0] rd_ret_address;
    logic              rd_ret_ack;
    logic [15:0]       wr_count;
    logic [15:0]       rd_count;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W),
        .RD_LATENCY(RD_L), .WR_LATENCY(WR_L)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
        .rd_address(rd_address), .rd_en(rd_en),
        .rd_ret_data(rd_ret_data), .rd_ret_address(rd_ret_address),
        .rd_ret_ack(rd_ret_ack),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    // ---------------- model ----------------
    typedef struct {
        int          due;
        logic [15:0] addr;
        logic [15:0] data;
        bit          known;
    } resp_t;

    resp_t       wr_q[$];
    resp_t       rd_q[$];
    logic [15:0] mem_m [int];
    int          edge_n    = 0;
    int          wr_cnt_m  = 0;
    int          rd_cnt_m  = 0;
    logic        exp_wr_ack = 1'b0;
    logic [15:0] exp_wr_addr = '0;
    logic        exp_rd_ack = 1'b0;
    logic [15:0] exp_rd_addr = '0;
    logic [15:0] exp_rd_data = '0;
    bit          exp_rd_known = 1'b0;

    // A request sampled at edge e is answered in the cycle after edge e+L-1,
    // i.e. L cycles after the cycle it was presented in.
    always @(posedge clk or posedge reset) begin
        resp_t r;
        int    wi;
        int    ri;
        edge_n++;
        if (reset) begin
            wr_q.delete();
            rd_q.delete();
            wr_cnt_m     = 0;
            rd_cnt_m     = 0;
            exp_wr_ack   = 1'b0;
            exp_wr_addr  = '0;
            exp_rd_ack   = 1'b0;
            exp_rd_addr  = '0;
            exp_rd_data  = '0;
            exp_rd_known = 1'b0;
        end else begin
            wi = int'(wr_address[IDX_W-1:0]);
            ri = int'(rd_address[IDX_W-1:0]);
            if (rd_en) begin
                r.due   = edge_n + int'(RD_L) - 1;
                r.addr  = rd_address;
                r.known = mem_m.exists(ri);
                r.data  = r.known ? mem_m[ri] : 16'h0000;
                rd_q.push_back(r);
                if (rd_cnt_m < 65535) rd_cnt_m++;
            end
            if (wr_en) begin
                mem_m[wi] = wr_data;
                r.due   = edge_n + int'(WR_L) - 1;
                r.addr  = wr_address;
                r.data  = 16'h0000;
                r.known = 1'b1;
                wr_q.push_back(r);
                if (wr_cnt_m < 65535) wr_cnt_m++;
            end
            exp_wr_ack   = 1'b0;
            exp_wr_addr  = '0;
            exp_rd_ack   = 1'b0;
            exp_rd_addr  = '0;
            exp_rd_data  = '0;
            exp_rd_known = 1'b1;
            if (wr_q.size() > 0 && wr_q[0].due == edge_n) begin
                r = wr_q.pop_front();
                exp_wr_ack  = 1'b1;
                exp_wr_addr = r.addr;
            end
            if (rd_q.size() > 0 && rd_q[0].due == edge_n) begin
                r = rd_q.pop_front();
                exp_rd_ack   = 1'b1;
                exp_rd_addr  = r.addr;
                exp_rd_data  = r.data;
                exp_rd_known = r.known;
            end
        end
    end

    // ---------------- literal expectations posted by the stimulus ----------------
    int          lit_sel [64];
    logic [15:0] lit_exp [64];
    int          lit_wr = 0;
    int          lit_rd = 0;

    task automatic lit(input int sel, input logic [15:0] e);
        lit_sel[lit_wr] = sel;
        lit_exp[lit_wr] = e;
        lit_wr++;
    endtask

    function automatic string sel_name(input int s);
        case (s)
            S_WR_ACK:  return "lit_wr_ret_ack";
            S_WR_ADDR: return "lit_wr_ret_address";
            S_RD_ACK:  return "lit_rd_ret_ack";
            S_RD_ADDR: return "lit_rd_ret_address";
            S_RD_DATA: return "lit_rd_ret_data";
            S_WR_CNT:  return "lit_wr_count";
            default:   return "lit_rd_count";
        endcase
    endfunction

    function automatic logic [31:0] out_sel(input int s);
        case (s)
            S_WR_ACK:  return 32'(wr_ret_ack);
            S_WR_ADDR: return 32'(wr_ret_address);
            S_RD_ACK:  return 32'(rd_ret_ack);
            S_RD_ADDR: return 32'(rd_ret_address);
            S_RD_DATA: return 32'(rd_ret_data);
            S_WR_CNT:  return 32'(wr_count);
            default:   return 32'(rd_count);
        endcase
    endfunction

    // ---------------- compare ----------------
    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s at edge %0d t=%0t: got %h expected %h", name, edge_n, $time, act, e);
        end
    endtask

    always @(negedge clk) begin
        cmp("wr_ret_ack", 32'(wr_ret_ack), 32'(exp_wr_ack));
        cmp("wr_ret_address", 32'(wr_ret_address), 32'(exp_wr_addr));
        cmp("rd_ret_ack", 32'(rd_ret_ack), 32'(exp_rd_ack));
        cmp("rd_ret_address", 32'(rd_ret_address), 32'(exp_rd_addr));
        if (exp_rd_known) cmp("rd_ret_data", 32'(rd_ret_data), 32'(exp_rd_data));
        cmp("wr_count", 32'(wr_count), 32'(wr_cnt_m));
        cmp("rd_count", 32'(rd_count), 32'(rd_cnt_m));
        while (lit_rd < lit_wr) begin
            cmp(sel_name(lit_sel[lit_rd]), out_sel(lit_sel[lit_rd]), 32'(lit_exp[lit_rd]));
            lit_rd++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                         input logic re, input logic [15:0] ra);
        wr_en      = we;
        wr_address = wa;
        wr_data    = wd;
        rd_en      = re;
        rd_address = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset state.
        for (int s = S_WR_ACK; s <= S_RD_CNT; s++) lit(s, 16'h0000);
        reset = 1'b0;

        // Write then read back.
        drive(1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0005);
        lit(S_WR_ACK, 16'h0001);
        lit(S_WR_ADDR, 16'h0005);
        idle(3);
        lit(S_RD_ACK, 16'h0001);
        lit(S_RD_DATA, 16'hBEEF);
        lit(S_RD_ADDR, 16'h0005);
        idle(4);

        // Same-cycle read/write is read-first.
        drive(1'b1, 16'h0010, 16'h0AAA, 1'b0, 16'h0);
        idle(3);
        drive(1'b1, 16'h0010, 16'h1234, 1'b1, 16'h0010);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0010);
        idle(2);
        lit(S_RD_DATA, 16'h0AAA);
        lit(S_RD_ADDR, 16'h0010);
        idle(1);
        lit(S_RD_DATA, 16'h1234);
        idle(4);

        // Aliasing above the index width.
        drive(1'b1, 16'h0403, 16'h7777, 1'b0, 16'h0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0003);
        idle(3);
        lit(S_RD_DATA, 16'h7777);
        lit(S_RD_ADDR, 16'h0003);
        idle(4);
        lit(S_WR_CNT, 16'd4);
        lit(S_RD_CNT, 16'd4);

        // Streaming: preload, reset counters, then 200 back-to-back pairs.
        for (int i = 0; i < 200; i++) drive(1'b1, 16'(i), 16'(16'h5000 + i), 1'b0, 16'h0);
        idle(4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 200; i++) drive(1'b1, 16'(i), 16'(i), 1'b1, 16'(i));
        idle(6);
        lit(S_WR_CNT, 16'd200);
        lit(S_RD_CNT, 16'd200);

        // Reset with reads in flight.
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0001);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0002);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 16'h0003);
        lit(S_RD_CNT, 16'd203);
        rd_en = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        lit(S_RD_ACK, 16'h0000);
        lit(S_RD_ADDR, 16'h0000);
        lit(S_RD_CNT, 16'h0000);
        lit(S_WR_CNT, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(8);

        // Write counter saturation.
        for (int i = 0; i < 65540; i++) drive(1'b1, 16'(i), 16'(i * 3), 1'b0, 16'h0);
        idle(1);
        lit(S_WR_ACK, 16'h0001);
        lit(S_WR_ADDR, 16'h0003);
        lit(S_WR_CNT, 16'hFFFF);
        lit(S_RD_CNT, 16'h0000);
        idle(4);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
